// File: rtl/basic_word_ram_pkg.sv
// basic_word_ram_pkg: access FSM state encoding and parameter defaults for basic_word_ram
package basic_word_ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 32;
    localparam int DEPTH_DEF   = 1024;
    localparam int LATENCY_DEF = 3;

endpackage

// File: rtl/basic_word_ram_array.sv
// basic_word_ram_array: single-port DEPTH x DATA_W synchronous RAM with a registered read port
module basic_word_ram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/basic_word_ram.sv
// basic_word_ram: word RAM behind an IDLE/BUSY/DONE handshake with a fixed access latency
module basic_word_ram
    import basic_word_ram_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_output,
    input  logic [DATA_W-1:0] data_input,
    output logic              mem_done,
    input  logic              cs,
    input  logic              we,
    input  logic              oe,
    input  logic              rst_n
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t            state;
    logic [3:0]        cnt;
    logic [AW-1:0]     addr_q;
    logic [DATA_W-1:0] din_q;
    logic              wr_q;
    logic              last;

    // The array acts on the edge that enters DONE, so commit and read-out line up with mem_done.
    assign last = (state == BUSY) && (cnt == 4'd1);

    generate
        if (ADDR_W > AW) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[ADDR_W-1:AW];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mem_done <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            wr_q     <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            case (state)
                IDLE: if (cs && (we || oe)) begin
                    addr_q <= address[AW-1:0];
                    din_q  <= data_input;
                    wr_q   <= we;
                    cnt    <= LAT;
                    state  <= BUSY;
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state    <= DONE;
                        mem_done <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    basic_word_ram_array #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (last && wr_q),
        .re   (last && !wr_q),
        .addr (addr_q),
        .wdata(din_q),
        .rdata(data_output)
    );

endmodule

// File: tb/tb_basic_word_ram.sv
// tb_basic_word_ram: directed checks of latency, read/write, wrap, abort and idle behaviour
module tb_basic_word_ram;

    logic        clk;
    logic [31:0] address;
    logic [31:0] data_output;
    logic [31:0] data_input;
    logic        mem_done;
    logic        cs;
    logic        we;
    logic        oe;
    logic        rst_n;

    int total = 0;
    int bad   = 0;
    int hits;

    basic_word_ram dut (
        .clk        (clk),
        .address    (address),
        .data_output(data_output),
        .data_input (data_input),
        .mem_done   (mem_done),
        .cs         (cs),
        .we         (we),
        .oe         (oe),
        .rst_n      (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; inputs are scrambled after the start edge to show they are ignored.
    task automatic do_access(input logic w, input logic r, input logic [31:0] a,
                             input logic [31:0] d, input string tag);
        int first;
        int n;
        cs = 1'b1; we = w; oe = r; address = a; data_input = d;
        @(posedge clk);
        first = 0;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                cs = 1'b0; we = 1'b0; oe = 1'b0;
                address = $urandom; data_input = $urandom;
            end
            if (mem_done) begin
                n++;
                if (first == 0) first = i;
            end
        end
        chk({tag, "_lat"}, first, 4);
        chk({tag, "_pulses"}, n, 1);
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b0; we = 1'b0; oe = 1'b0;
        address = '0; data_input = '0;
        repeat (3) @(negedge clk);
        chk("reset_dout", data_output, 32'h0);
        chk("reset_done", {31'b0, mem_done}, 32'h0);
        rst_n = 1'b1;

        do_access(1'b1, 1'b0, 32'd0, 32'hDEADBEEF, "wr_first");
        chk("wr_first_dout", data_output, 32'h0);

        do_access(1'b1, 1'b0, 32'd0, 32'h11111111, "wr0");
        do_access(1'b1, 1'b0, 32'd1, 32'h22222222, "wr1");
        do_access(1'b1, 1'b0, 32'd2, 32'h33333333, "wr2");

        cs = 1'b1; we = 1'b0; oe = 1'b1;
        address = 32'd0; repeat (10) @(negedge clk);
        chk("held_rd0", data_output, 32'h11111111);
        address = 32'd1; repeat (10) @(negedge clk);
        chk("held_rd1", data_output, 32'h22222222);
        address = 32'd2; repeat (10) @(negedge clk);
        chk("held_rd2", data_output, 32'h33333333);
        cs = 1'b0; oe = 1'b0;
        repeat (6) @(negedge clk);

        do_access(1'b1, 1'b1, 32'd5, 32'hA5A5A5A5, "wr_and_oe");
        chk("wr_and_oe_dout", data_output, 32'h33333333);
        do_access(1'b0, 1'b1, 32'd5, 32'h0, "rd5");
        chk("rd5_dout", data_output, 32'hA5A5A5A5);

        do_access(1'b1, 1'b0, 32'd1027, 32'h12345678, "wr_wrap");
        do_access(1'b0, 1'b1, 32'd3, 32'h0, "rd_wrap");
        chk("rd_wrap_dout", data_output, 32'h12345678);
        do_access(1'b1, 1'b0, 32'd3, 32'h0BADF00D, "wr_same");
        chk("wr_same_dout", data_output, 32'h12345678);
        do_access(1'b0, 1'b1, 32'd3, 32'h0, "rd_same");
        chk("rd_same_dout", data_output, 32'h0BADF00D);

        do_access(1'b1, 1'b0, 32'd7, 32'h77777777, "wr7");
        cs = 1'b1; we = 1'b1; oe = 1'b0; address = 32'd7; data_input = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        hits = mem_done ? 1 : 0;
        rst_n = 1'b0;
        @(negedge clk);
        if (mem_done) hits++;
        chk("abort_rst_dout", data_output, 32'h0);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (mem_done) hits++;
        end
        chk("abort_no_done", hits, 0);
        do_access(1'b0, 1'b1, 32'd7, 32'h0, "rd7");
        chk("rd7_dout", data_output, 32'h77777777);

        cs = 1'b0; we = 1'b0; oe = 1'b1; address = 32'd0;
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_done) hits++;
        end
        oe = 1'b0;
        chk("cs_off_done", hits, 0);
        chk("cs_off_dout", data_output, 32'h77777777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/basic_word_ram.md
BASIC_WORD_RAM -- requirements
Module: basic_word_ram

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_W, default 32: word width in bits.
REQ-003 Parameter ADDR_W, default 32: address port width in bits.
REQ-004 Parameter DEPTH, default 1024: number of words, a power of two.
REQ-005 Parameter LATENCY, default 3: number of BUSY cycles per access, legal range 1..15.
REQ-006 Ports SHALL be declared in this positional order: clk, address, data_output, data_input, mem_done, cs, we, oe, rst_n.
REQ-007 clk  input  1: rising-edge clock.
REQ-008 rst_n  input  1: asynchronous, active-low reset.
REQ-009 address  input  ADDR_W: word address; bits [log2(DEPTH)-1:0] are used and upper bits are ignored, so addresses wrap modulo DEPTH.
REQ-010 data_output  output  DATA_W: registered read data.
REQ-011 data_input  input  DATA_W: write data.
REQ-012 mem_done  output  1: single-cycle access-complete pulse.
REQ-013 cs  input  1: chip select, active high.
REQ-014 we  input  1: write request, active high.
REQ-015 oe  input  1: read (output enable) request, active high.

Function
REQ-016 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-017 In IDLE, a rising edge with cs=1 and (we=1 or oe=1) SHALL start an access: capture address, data_input and op (write if we=1, else read), load the counter with LATENCY, and go to BUSY.
REQ-018 If we=1 and oe=1 together, the access SHALL be a write (write wins).
REQ-019 BUSY SHALL decrement the counter each cycle and go to DONE after exactly LATENCY cycles.
REQ-020 On entry to DONE, a write SHALL commit the captured data to the captured address; a read SHALL load data_output from that address.
REQ-021 mem_done SHALL be high for exactly the one DONE cycle.
REQ-022 DONE SHALL always return to IDLE, so a held request re-issues with one idle cycle between accesses; access period is LATENCY+2 cycles.
REQ-023 A new access SHALL re-sample address and data_input, so a held oe re-reads, and a held we re-writes, the current address.
REQ-024 Once started, an access SHALL complete even if cs, we, oe or address change.
REQ-025 Input changes during BUSY SHALL NOT affect the in-flight access.
REQ-026 data_output SHALL hold the last read value between reads and SHALL NOT change on writes, including a write to the last-read address.
REQ-027 Reading a word never written since power-up SHALL return an undefined value, but SHALL still produce mem_done on time.
REQ-028 With cs=0 in IDLE, no access SHALL start and there SHALL be no side effects.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, counter 0, mem_done 0, data_output 0, captured registers 0.
REQ-030 Reset during BUSY SHALL abort the access with no memory write and no mem_done pulse.
REQ-031 Memory contents SHALL NOT be reset; the array is inferable as block RAM.
REQ-032 The first access SHALL be able to start on the first rising edge after rst_n deasserts.

Structure
REQ-033 Package basic_word_ram_pkg SHALL hold the state enum (IDLE, BUSY, DONE) and the parameter defaults.
REQ-034 There SHALL be one sub-module, basic_word_ram_array: a synchronous single-port DEPTH x DATA_W array with one write port and one registered read port.
REQ-035 The FSM and counter SHALL live in the top level.

Verification
REQ-036 Reset, then write 0xDEADBEEF at address 0 -> mem_done pulses exactly 4 cycles after the start edge; data_output stays 0.
REQ-037 Write 0x11111111, 0x22222222, 0x33333333 to addresses 0, 1, 2, then read back with oe held while address steps 0, 1, 2 at 10-cycle intervals -> data_output shows 0x11111111, then 0x22222222, then 0x33333333.
REQ-038 Assert we=1 and oe=1 at address 5 with data 0xA5A5A5A5 -> a write occurs; a later read of address 5 returns 0xA5A5A5A5; data_output is unchanged by the write.
REQ-039 Write 0x12345678 at address DEPTH+3, then read address 3 -> returns 0x12345678.
REQ-040 Start a write of 0xCAFEF00D at address 7, assert rst_n=0 during BUSY, release, then read address 7 -> no mem_done during the aborted access; the read returns the prior contents, not 0xCAFEF00D.
REQ-041 Hold oe=1 with cs=0 for 20 cycles -> mem_done never asserts and data_output holds.
